// File: rtl/apb_slave_regs.sv
// APB register slave: read-only ID in slot 0, NUM_REGS-1 byte-strobed
// read/write registers, optional wait states and registered responses.
module apb_slave_regs #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           pselx,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int IW = $clog2(NUM_REGS);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [CW-1:0]         CNT_LOAD   = CW'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t                                  state_q, state_d;
    logic [CW-1:0]                           cnt_q, cnt_d;
    logic [IW-1:0]                           idx_q, idx_d;
    logic                                    err_q, err_d;
    logic                                    wr_q, wr_d;
    logic                                    pready_q, pready_d;
    logic                                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]                   prdata_q, prdata_d;
    logic [NUM_REGS-1:1][DATA_WIDTH-1:0]     regs_q, regs_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]     regs_view;

    logic          setup;
    logic [IW-1:0] a_idx;
    logic          a_err;
    logic          do_wr;
    logic          unused_prot;

    // Protection attributes carry no meaning for this block.
    assign unused_prot = ^pprot;

    // Setup-phase decode; these are only captured on the setup edge.
    assign setup = (state_q == IDLE) && pselx && !penable;
    assign a_idx = paddr[IW+1:2];
    assign a_err = (paddr[1:0] != 2'b00) || (paddr >= ADDR_LIMIT) ||
                   (pwrite && (a_idx == '0));

    // Register map view: slot 0 is the constant ID, the rest are storage.
    always_comb begin
        regs_view    = '0;
        regs_view[0] = ID_VALUE;
        for (int k = 1; k < NUM_REGS; k++) regs_view[k] = regs_q[k];
    end

    // Transfer FSM: setup capture, wait-state countdown, abort, completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    idx_d = a_idx;
                    err_d = a_err;
                    wr_d  = pwrite;
                    if (WAIT_STATES == 0) begin
                        state_d = READY;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!pselx) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            READY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered response; read data loads only when a read enters READY.
    always_comb begin
        pready_d  = (state_d == READY);
        pslverr_d = (state_d == READY) && err_d;
        prdata_d  = prdata_q;
        if ((state_d == READY) && (state_q != READY) && !wr_d)
            prdata_d = err_d ? '0 : regs_view[idx_d];
    end

    // Byte-strobed write on the completion edge; pwdata/pstrb sampled here.
    always_comb begin
        regs_d = regs_q;
        do_wr  = (state_q == READY) && pselx && penable && pwrite && wr_q && !err_q;
        if (do_wr) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (idx_q == IW'(k)) begin
                    for (int b = 0; b < SW; b++)
                        if (pstrb[b]) regs_d[k][b*8 +: 8] = pwdata[b*8 +: 8];
                end
            end
        end
    end

    // State and register flops.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            regs_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;
    assign regs_o  = regs_view;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench: dut0 has no wait states, dut3 has three.
module tb_apb_slave_regs;

    logic         pclk = 1'b0;
    logic         preset;
    logic [31:0]  paddr;
    logic [2:0]   pprot;
    logic         psel0, psel3, penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [31:0]  prdata0, prdata3;
    logic [255:0] regs0, regs3;
    logic [255:0] exp_rst;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_slave_regs #(.WAIT_STATES(0)) dut0 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot),
        .pselx(psel0), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready0), .prdata(prdata0),
        .pslverr(pslverr0), .regs_o(regs0));

    apb_slave_regs #(.WAIT_STATES(3)) dut3 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot),
        .pselx(psel3), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready3), .prdata(prdata3),
        .pslverr(pslverr3), .regs_o(regs3));

    task automatic sel(input int which, input logic v);
        if (which == 0) psel0 = v; else psel3 = v;
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? pready0 : pready3;
    endfunction

    // One complete transfer. Setup carries junk write data/strobes so only
    // the values present at completion can land in the register.
    task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err, output int acc);
        sel(which, 1'b1); penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = ~wd; pstrb = ~st;
        @(posedge pclk); #1;
        penable = 1'b1; pwdata = wd; pstrb = st; acc = 1;
        while (!rdy(which) && acc < 20) begin
            @(posedge pclk); #1;
            acc++;
        end
        if (!rdy(which)) begin
            checks++; errors++;
            $display("FAIL xfer_timeout addr=%h pready stayed 0", addr);
        end
        rd  = (which == 0) ? prdata0 : prdata3;
        err = (which == 0) ? pslverr0 : pslverr3;
        @(posedge pclk); #1;
        sel(which, 1'b0); penable = 1'b0;
    endtask

    task automatic test_reset;
        preset = 1'b1; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
        paddr = '0; pprot = 3'b010; pwdata = '0; pstrb = '0;
        #3;
        checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL rst_pready0 got %b exp 0", pready0); end
        checks++; if (pslverr0 !== 1'b0) begin errors++; $display("FAIL rst_pslverr0 got %b exp 0", pslverr0); end
        checks++; if (prdata0 !== 32'h0) begin errors++; $display("FAIL rst_prdata0 got %h exp 0", prdata0); end
        checks++; if (regs0 !== exp_rst) begin errors++; $display("FAIL rst_regs0 got %h exp %h", regs0, exp_rst); end
        checks++; if (pready3 !== 1'b0) begin errors++; $display("FAIL rst_pready3 got %b exp 0", pready3); end
        @(posedge pclk); #1;
        preset = 1'b0;
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic err; int acc;
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, err, acc);
        checks++; if (acc !== 1) begin errors++; $display("FAIL wr_latency got %0d exp 1", acc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_pslverr got %b exp 0", err); end
        checks++; if (regs0[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_slot1 got %h exp DEADBEEF", regs0[63:32]); end
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, acc);
        checks++; if (acc !== 1) begin errors++; $display("FAIL rd_latency got %0d exp 1", acc); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp DEADBEEF", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_pslverr got %b exp 0", err); end
    endtask

    task automatic test_strobe;
        logic [31:0] rd; logic err; int acc;
        xfer(0, 1'b1, 32'h08, 32'h11223344, 4'hF, rd, err, acc);
        xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, rd, err, acc);
        checks++; if (regs0[95:64] !== 32'h11BB33DD) begin errors++; $display("FAIL strb_slot2 got %h exp 11BB33DD", regs0[95:64]); end
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, acc);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb_read got %h exp 11BB33DD", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic err; int acc;
        xfer(0, 1'b1, 32'h00, 32'h0, 4'hF, rd, err, acc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_wr_id got %b exp 1", err); end
        checks++; if (regs0[31:0] !== 32'hA5B00001) begin errors++; $display("FAIL err_id_slot got %h exp A5B00001", regs0[31:0]); end
        checks++; if (pslverr0 !== 1'b0) begin errors++; $display("FAIL err_idle_pslverr got %b exp 0", pslverr0); end
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, acc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_oor got %b exp 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_oor_data got %h exp 0", rd); end
        xfer(0, 1'b0, 32'h06, 32'h0, 4'h0, rd, err, acc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misalign got %b exp 1", err); end
        xfer(0, 1'b1, 32'h05, 32'hFFFFFFFF, 4'hF, rd, err, acc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misalign_wr got %b exp 1", err); end
        checks++; if (regs0[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_no_write got %h exp DEADBEEF", regs0[63:32]); end
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, acc);
        checks++; if (rd !== 32'hA5B00001) begin errors++; $display("FAIL id_read got %h exp A5B00001", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL id_pslverr got %b exp 0", err); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic err; int acc;
        xfer(0, 1'b1, 32'h0C, 32'h0BADF00D, 4'hF, rd, err, acc);
        xfer(0, 1'b1, 32'h1C, 32'h76543210, 4'hF, rd, err, acc);
        checks++; if (acc !== 1) begin errors++; $display("FAIL b2b_latency got %0d exp 1", acc); end
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, err, acc);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_rd3 got %h exp 0BADF00D", rd); end
        xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, rd, err, acc);
        checks++; if (rd !== 32'h76543210) begin errors++; $display("FAIL b2b_rd7 got %h exp 76543210", rd); end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; logic err; int acc;
        xfer(3, 1'b1, 32'h04, 32'h12345678, 4'hF, rd, err, acc);
        checks++; if (acc !== 4) begin errors++; $display("FAIL ws_wr_latency got %0d exp 4", acc); end
        checks++; if (regs3[63:32] !== 32'h12345678) begin errors++; $display("FAIL ws_slot1 got %h exp 12345678", regs3[63:32]); end
        xfer(3, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, acc);
        checks++; if (acc !== 4) begin errors++; $display("FAIL ws_rd_latency got %0d exp 4", acc); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL ws_rd_data got %h exp 12345678", rd); end
        // Aborted write: one access cycle, then pselx drops.
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        checks++; if (pready3 !== 1'b0) begin errors++; $display("FAIL abort_pready_acc got %b exp 0", pready3); end
        @(posedge pclk); #1;
        psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        checks++; if (pready3 !== 1'b0) begin errors++; $display("FAIL abort_pready got %b exp 0", pready3); end
        @(posedge pclk); #1;
        checks++; if (regs3[63:32] !== 32'h12345678) begin errors++; $display("FAIL abort_no_write got %h exp 12345678", regs3[63:32]); end
        xfer(3, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, acc);
        checks++; if (acc !== 4) begin errors++; $display("FAIL abort_then_latency got %0d exp 4", acc); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_then_rd got %h exp 12345678", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic err; int acc; int n;
        // dut0: reset while a write sits in READY.
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        checks++; if (pready0 !== 1'b1) begin errors++; $display("FAIL rmid_pre_pready got %b exp 1", pready0); end
        #2 preset = 1'b1;
        #1;
        checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL rmid_pready got %b exp 0", pready0); end
        checks++; if (regs0 !== exp_rst) begin errors++; $display("FAIL rmid_regs0 got %h exp %h", regs0, exp_rst); end
        checks++; if (prdata0 !== 32'h0) begin errors++; $display("FAIL rmid_prdata got %h exp 0", prdata0); end
        @(posedge pclk); #1;
        preset = 1'b0; psel0 = 1'b0; penable = 1'b0;
        xfer(0, 1'b1, 32'h04, 32'h00C0FFEE, 4'hF, rd, err, acc);
        checks++; if (acc !== 1) begin errors++; $display("FAIL rmid_after_latency got %0d exp 1", acc); end
        checks++; if (regs0[63:32] !== 32'h00C0FFEE) begin errors++; $display("FAIL rmid_after_wr got %h exp 00C0FFEE", regs0[63:32]); end
        // dut3: reset during the second of two back-to-back writes.
        xfer(3, 1'b1, 32'h08, 32'h55AA55AA, 4'hF, rd, err, acc);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
        pwdata = 32'h01020304; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1; n = 0;
        while (!pready3 && n < 10) begin
            @(posedge pclk); #1;
            n++;
        end
        checks++; if (pready3 !== 1'b1) begin errors++; $display("FAIL rb2b_pre_pready got %b exp 1", pready3); end
        preset = 1'b1;
        #1;
        checks++; if (pready3 !== 1'b0) begin errors++; $display("FAIL rb2b_pready got %b exp 0", pready3); end
        checks++; if (regs3 !== exp_rst) begin errors++; $display("FAIL rb2b_regs3 got %h exp %h", regs3, exp_rst); end
        @(posedge pclk); #1;
        preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        xfer(3, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, acc);
        checks++; if (acc !== 4) begin errors++; $display("FAIL rb2b_after_latency got %0d exp 4", acc); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rb2b_after_rd got %h exp 0", rd); end
        xfer(3, 1'b1, 32'h0C, 32'h00000077, 4'hF, rd, err, acc);
        checks++; if (regs3[127:96] !== 32'h00000077) begin errors++; $display("FAIL rb2b_after_wr got %h exp 00000077", regs3[127:96]); end
    endtask

    initial begin
        exp_rst = {224'h0, 32'hA5B00001};
        test_reset();
        test_write_read();
        test_strobe();
        test_errors();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
